// File: rtl/datapath_ula.sv
// Three-register datapath (X operand, Y accumulator, Z result) around a small ULA.
// All registers update together on the rising edge from their pre-edge values.
module datapath_ula #(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [N-1:0] data_in,
    input  logic [3:0]   Tx,
    input  logic [3:0]   Ty,
    input  logic [3:0]   Tz,
    input  logic [3:0]   Tula,
    output logic [N-1:0] X,
    output logic [N-1:0] Y,
    output logic [N-1:0] Z,
    output logic         carry,
    output logic         zero,
    output logic [N-1:0] ula_out
);

    localparam logic [3:0] OP_HOLD   = 4'd0;
    localparam logic [3:0] OP_LOAD   = 4'd1;
    localparam logic [3:0] OP_SHIFTR = 4'd2;
    localparam logic [3:0] OP_SHIFTL = 4'd3;
    localparam logic [3:0] OP_RESET  = 4'd4;

    localparam logic [3:0] ULA_ADD   = 4'd0;
    localparam logic [3:0] ULA_SUB   = 4'd1;
    localparam logic [3:0] ULA_MAIOR = 4'd2;
    localparam logic [3:0] ULA_MENOR = 4'd3;
    localparam logic [3:0] ULA_IGUAL = 4'd4;
    localparam logic [3:0] ULA_XOR   = 4'd5;
    localparam logic [3:0] ULA_AND   = 4'd6;

    logic [N-1:0] r_x;
    logic [N-1:0] r_y;
    logic [N-1:0] r_z;
    logic         r_carry;
    logic         r_zero;

    logic [N:0]   w_sum;
    logic [N-1:0] w_ula;
    logic         w_cout;

    // No handshake: opcodes are sampled every edge, so a held opcode repeats its action.
    function automatic logic [N-1:0] reg_next(input logic [N-1:0] cur,
                                              input logic [3:0]   op,
                                              input logic [N-1:0] load_val);
        logic [N-1:0] nxt;
        nxt = cur;
        case (op)
            OP_LOAD:   nxt = load_val;
            OP_SHIFTR: nxt = {1'b0, cur[N-1:1]};
            OP_SHIFTL: nxt = {cur[N-2:0], 1'b0};
            OP_RESET:  nxt = '0;
            default:   nxt = cur;
        endcase
        return nxt;
    endfunction

    always_comb begin
        w_sum  = {1'b0, r_x} + {1'b0, r_y};
        w_ula  = '0;
        w_cout = 1'b0;
        case (Tula)
            ULA_ADD: begin
                w_ula  = w_sum[N-1:0];
                w_cout = w_sum[N];
            end
            ULA_SUB: begin
                w_ula  = r_x - r_y;
                w_cout = (r_x < r_y);
            end
            ULA_MAIOR: w_ula = {{(N-1){1'b0}}, (r_x > r_y)};
            ULA_MENOR: w_ula = {{(N-1){1'b0}}, (r_x < r_y)};
            ULA_IGUAL: w_ula = {{(N-1){1'b0}}, (r_x == r_y)};
            ULA_XOR:   w_ula = r_x ^ r_y;
            ULA_AND:   w_ula = r_x & r_y;
            default:   w_ula = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_x <= reg_next(r_x, Tx, data_in);
            r_y <= reg_next(r_y, Ty, w_ula);
            r_z <= reg_next(r_z, Tz, r_y);
            // Flags track the accumulator: captured on Y LOAD, cleared on Y RESET.
            if (Ty == OP_LOAD) begin
                r_carry <= w_cout;
                r_zero  <= (w_ula == '0);
            end else if (Ty == OP_RESET) begin
                r_carry <= 1'b0;
                r_zero  <= 1'b0;
            end
        end
    end

    assign X       = r_x;
    assign Y       = r_y;
    assign Z       = r_z;
    assign carry   = r_carry;
    assign zero    = r_zero;
    assign ula_out = w_ula;

endmodule
